debug_uart_tx_wb: RTL and testbench
===================================

// Module: debug_uart_tx_wb
// PURPOSE
//  Synthesizable Wishbone console for debug output. Bytes written to TXDATA are
//  queued in a small FIFO and serialized 8N1, LSB first, on uart_tx_o.
//  Sits on the Wishbone bus as a slave beside the simulation-only debug port,
//  so firmware can send text on real hardware through the same write path.
// PARAMETERS
//  CLK_DIV     868  clocks per UART bit (100 MHz / 115200); legal range >= 2
//  FIFO_DEPTH  16   TX FIFO entries; power of two, >= 2
//  FIFO_AW     4    log2(FIFO_DEPTH)
// PORTS
//  wb_clk_i    in   1   clock
//  wb_rst_i    in   1   asynchronous reset, active-high
//  wb_cyc_i    in   1   bus cycle
//  wb_stb_i    in   1   strobe
//  wb_we_i     in   1   write enable
//  wb_adr_i    in   32  byte address; only [3:2] decoded
//  wb_dat_i    in   32  write data
//  wb_sel_i    in   4   byte selects
//  wb_stall_o  out  1   pipelined-mode stall
//  wb_ack_o    out  1   access acknowledge
//  wb_dat_o    out  32  read data
//  wb_err_o    out  1   access error (reserved offset)
//  uart_tx_o   out  1   serial output; idle high
//  tx_busy_o   out  1   FIFO non-empty or a frame is in flight
// BEHAVIOUR
//  Reset values: ack=0, err=0, dat_o=0, uart_tx_o=1, FIFO empty, FSM=IDLE.
//  Reset mid-frame aborts the frame: line returns high at once, queued bytes are lost.
//  Register map (adr[3:2]):
//   0 TXDATA: W pushes dat_i[7:0] if sel[0]=1. With sel[0]=0 the write is acked and nothing is pushed. Reads return 0.
//   1 STATUS: R {16'b0, level[7:0], 5'b0, busy, empty, full}. W is acked and ignored.
//   2,3 reserved: err_o instead of ack.
//  Accept = cyc & stb & ~stall.
//  stall_o = cyc & stb & we & (adr[3:2]==0) & fifo_full (combinational).
//  ack_o or err_o is registered and pulses one cycle after accept. They are never both high.
//  Each accept gets exactly one response. Back-to-back accepts give back-to-back acks.
//  dat_o is registered alongside ack.
//  FIFO: synchronous read and write pointers of FIFO_AW bits that wrap modulo depth.
//   Count is FIFO_AW+1 bits wide. full when count==DEPTH; empty when count==0.
//   Push and pop in the same cycle leave count unchanged.
//   Push while full cannot occur (stalled). Pop occurs only when non-empty.
//  TX FSM: IDLE -> START -> DATA -> STOP -> IDLE.
//   IDLE: tx=1. If not empty, pop into shift reg, baud_cnt=CLK_DIV-1, go to START.
//   START: tx=0 for CLK_DIV clocks.
//   DATA: tx=shift[0] for 8 bits of CLK_DIV clocks each, shifting right. A 3-bit counter tracks the bits.
//   STOP: tx=1 for CLK_DIV clocks, then IDLE.
//   Frame length is 10*CLK_DIV clocks. Consecutive frames have a 1-clock idle gap.
//  uart_tx_o is driven from a register (glitch-free).
//  tx_busy_o = (state!=IDLE) | ~empty. STATUS.busy reports the same signal.
//  A push landing on the cycle IDLE samples empty is seen in the next cycle.
// STRUCTURE
//  Package debug_uart_pkg holds:
//   register offsets: TXDATA=0, STATUS=1
//   STATUS bit positions
//   FSM state encoding
//  Sub-module sync_fifo: generic WIDTH/DEPTH, push/pop/full/empty/count, async reset.
//  Top level holds the WB decode, the response registers and the TX FSM with baud counter.
// TESTING (CLK_DIV=4, FIFO_DEPTH=4)
//  1 Reset, idle 50 clks -> uart_tx_o=1, ack=0, busy=0. STATUS read returns 0x00000002.
//  2 Write 0x41 to TXDATA -> ack 1 clk later. tx line carries 0 then bits 1,0,0,0,0,0,1,0, then 1, each 4 clks. 40-clk frame, busy falls afterwards.
//  3 Write 6 bytes back-to-back -> stall asserts when count hits 4. All 6 bytes appear on the line in order, with a 1-clk gap between frames.
//  4 Access adr 0x8 (R and W) -> err pulses 1 clk later, ack stays 0. FIFO is unchanged.
//  5 Write with sel=4'b1110 -> ack, no push, line stays idle.
//  6 Assert reset in the middle of DATA -> uart_tx_o=1 immediately, FIFO empty. Line stays idle after release.

Source files
------------

// File: rtl/debug_uart_pkg.sv
// Shared constants for the Wishbone debug UART: register offsets,
// STATUS bit layout and the transmitter state encoding.
package debug_uart_pkg;

  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;

  localparam int STAT_FULL      = 0;
  localparam int STAT_EMPTY     = 1;
  localparam int STAT_BUSY      = 2;
  localparam int STAT_LEVEL_LSB = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrapping pointers and an explicit occupancy count.
// Caller guarantees no push when full and no pop when empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  localparam logic [AW-1:0] PTR_ONE    = 1;
  localparam logic [AW:0]   CNT_ONE    = 1;
  localparam logic [AW:0]   FULL_COUNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; only the pointers define valid contents.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign pop_data = mem[rd_ptr];
  assign full     = (count == FULL_COUNT);
  assign empty    = (count == '0);

endmodule

// File: rtl/debug_uart_tx_wb.sv
// Wishbone slave console: TXDATA writes are queued and shifted out 8N1, LSB
// first, on a registered serial line; STATUS reports FIFO level and activity.
module debug_uart_tx_wb
  import debug_uart_pkg::*;
#(
  parameter int CLK_DIV    = 868,
  parameter int FIFO_DEPTH = 16,
  parameter int FIFO_AW    = 4
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  output logic        wb_stall_o,
  output logic        wb_ack_o,
  output logic [31:0] wb_dat_o,
  output logic        wb_err_o,
  output logic        uart_tx_o,
  output logic        tx_busy_o
);

  localparam int BAUD_W = $clog2(CLK_DIV);
  localparam logic [BAUD_W-1:0] BAUD_MAX = BAUD_W'(CLK_DIV - 1);
  localparam logic [BAUD_W-1:0] BAUD_ONE = 1;

  logic               fifo_push;
  logic               fifo_pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [7:0]         fifo_rdata;
  logic [FIFO_AW:0]   fifo_count;
  logic [1:0]         reg_sel;
  logic               accept;
  logic               busy;
  logic [31:0]        status_word;
  tx_state_t          state;
  logic [BAUD_W-1:0]  baud_cnt;
  logic [2:0]         bit_cnt;
  logic [7:0]         shift;
  logic               unused_bits;

  assign unused_bits = ^{wb_adr_i[31:4], wb_adr_i[1:0], wb_dat_i[31:8], wb_sel_i[3:1]};

  // Handshake: a request (cyc & stb) is accepted on any clock where stall is
  // low; stall only holds off TXDATA writes while the FIFO is full. Every
  // accept gets exactly one registered ack or err on the following clock.
  assign reg_sel    = wb_adr_i[3:2];
  assign wb_stall_o = wb_cyc_i & wb_stb_i & wb_we_i & (reg_sel == REG_TXDATA) & fifo_full;
  assign accept     = wb_cyc_i & wb_stb_i & ~wb_stall_o;
  assign fifo_push  = accept & wb_we_i & (reg_sel == REG_TXDATA) & wb_sel_i[0];
  assign fifo_pop   = (state == ST_IDLE) & ~fifo_empty;
  assign busy       = (state != ST_IDLE) | ~fifo_empty;
  assign tx_busy_o  = busy;

  always_comb begin
    status_word = '0;
    status_word[STAT_LEVEL_LSB +: 8] = 8'(fifo_count);
    status_word[STAT_BUSY]  = busy;
    status_word[STAT_EMPTY] = fifo_empty;
    status_word[STAT_FULL]  = fifo_full;
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clk       (wb_clk_i),
    .rst       (wb_rst_i),
    .push      (fifo_push),
    .push_data (wb_dat_i[7:0]),
    .pop       (fifo_pop),
    .pop_data  (fifo_rdata),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      wb_ack_o <= accept & ~reg_sel[1];
      wb_err_o <= accept & reg_sel[1];
      wb_dat_o <= (accept && !wb_we_i && reg_sel == REG_STATUS) ? status_word : '0;
    end
  end

  // tx is loaded on each state transition so the line level always matches
  // the bit currently being timed by baud_cnt.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state     <= ST_IDLE;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
      uart_tx_o <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          uart_tx_o <= 1'b1;
          if (!fifo_empty) begin
            shift     <= fifo_rdata;
            baud_cnt  <= BAUD_MAX;
            uart_tx_o <= 1'b0;
            state     <= ST_START;
          end
        end
        ST_START: begin
          if (baud_cnt == '0) begin
            baud_cnt  <= BAUD_MAX;
            bit_cnt   <= '0;
            uart_tx_o <= shift[0];
            state     <= ST_DATA;
          end else begin
            baud_cnt <= baud_cnt - BAUD_ONE;
          end
        end
        ST_DATA: begin
          if (baud_cnt == '0) begin
            baud_cnt <= BAUD_MAX;
            if (bit_cnt == 3'd7) begin
              uart_tx_o <= 1'b1;
              state     <= ST_STOP;
            end else begin
              shift     <= {1'b0, shift[7:1]};
              uart_tx_o <= shift[1];
              bit_cnt   <= bit_cnt + 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt - BAUD_ONE;
          end
        end
        ST_STOP: begin
          if (baud_cnt == '0) begin
            uart_tx_o <= 1'b1;
            state     <= ST_IDLE;
          end else begin
            baud_cnt <= baud_cnt - BAUD_ONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_debug_uart_tx_wb.sv
// Bench for debug_uart_tx_wb: bus responses and serial frames are both
// checked by monitors against expected queues filled by the stimulus.
module tb_debug_uart_tx_wb;

  localparam int CLK_DIV    = 4;
  localparam int FIFO_DEPTH = 4;
  localparam int FIFO_AW    = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cyc = 1'b0;
  logic        stb = 1'b0;
  logic        we  = 1'b0;
  logic [31:0] adr = '0;
  logic [31:0] dat_w = '0;
  logic [3:0]  sel = '0;
  logic        stall;
  logic        ack;
  logic        err;
  logic [31:0] dat_r;
  logic        uart_tx;
  logic        busy;

  int checks   = 0;
  int failures = 0;
  int cycle    = 0;
  int stall_seen = 0;

  typedef struct {
    logic        ack;
    logic        err;
    logic [31:0] dat;
    int          cyc;
  } resp_t;

  resp_t      resp_q[$];
  logic [7:0] exp_q[$];
  int         frame_start[$];

  debug_uart_tx_wb #(
    .CLK_DIV    (CLK_DIV),
    .FIFO_DEPTH (FIFO_DEPTH),
    .FIFO_AW    (FIFO_AW)
  ) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .wb_cyc_i   (cyc),
    .wb_stb_i   (stb),
    .wb_we_i    (we),
    .wb_adr_i   (adr),
    .wb_dat_i   (dat_w),
    .wb_sel_i   (sel),
    .wb_stall_o (stall),
    .wb_ack_o   (ack),
    .wb_dat_o   (dat_r),
    .wb_err_o   (err),
    .uart_tx_o  (uart_tx),
    .tx_busy_o  (busy)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- check helper ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic wb_issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input logic e_ack, input logic e_err,
                          input logic [31:0] e_dat);
    resp_t r;
    int budget;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_w = d; sel = s;
    #1;
    budget = 0;
    while (stall && budget < 200) begin
      stall_seen++;
      @(negedge clk);
      #1;
      budget++;
    end
    if (stall) begin
      checks++;
      failures++;
      $display("FAIL stall_timeout: stall=1 after %0d cycles expected 0", budget);
    end
    r.ack = e_ack;
    r.err = e_err;
    r.dat = e_dat;
    r.cyc = cycle + 1;
    resp_q.push_back(r);
  endtask

  task automatic wb_idle();
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; dat_w = '0; sel = '0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((busy || resp_q.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (busy || resp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL idle_timeout: busy=%0b pending_resp=%0d expected 0/0", busy, resp_q.size());
    end
    repeat (CLK_DIV * 2) @(negedge clk);
  endtask

  task automatic expect_line_idle(input string name, input int n);
    int lows;
    int busies;
    lows = 0;
    busies = 0;
    repeat (n) begin
      @(negedge clk);
      if (!uart_tx) lows++;
      if (busy) busies++;
    end
    check({name, "_tx_low_clks"}, lows, 0);
    check({name, "_busy_clks"}, busies, 0);
  endtask

  // ---------------- scoreboard: bus response monitor ----------------
  always @(negedge clk) begin : resp_mon
    resp_t r;
    if (!rst && (ack || err)) begin
      check("ack_err_excl", {31'b0, ack & err}, 32'd0);
      if (resp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_resp: ack=%0b err=%0b expected no response", ack, err);
      end else begin
        r = resp_q.pop_front();
        check("resp_ack", {31'b0, ack}, {31'b0, r.ack});
        check("resp_err", {31'b0, err}, {31'b0, r.err});
        check("resp_dat", dat_r, r.dat);
        check("resp_cycle", cycle, r.cyc);
      end
    end
  end

  // ---------------- scoreboard: serial line monitor ----------------
  task automatic rx_frame();
    logic [7:0] b;
    logic [7:0] e;
    @(negedge clk);
    if (rst) return;
    frame_start.push_back(cycle);
    @(negedge clk);
    if (rst) return;
    check("start_bit", {31'b0, uart_tx}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      repeat (CLK_DIV) @(negedge clk);
      if (rst) return;
      b[i] = uart_tx;
    end
    repeat (CLK_DIV) @(negedge clk);
    if (rst) return;
    check("stop_bit", {31'b0, uart_tx}, 32'd1);
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_frame: byte 0x%02h expected none", b);
    end else begin
      e = exp_q.pop_front();
      check("rx_byte", {24'b0, b}, {24'b0, e});
    end
  endtask

  initial begin
    forever begin
      @(negedge uart_tx);
      if (!rst) rx_frame();
    end
  end

  // ---------------- stimulus ----------------
  logic [7:0] burst[6];
  int         busy_cnt;

  initial begin
    burst = '{8'h55, 8'hA3, 8'h0F, 8'hF0, 8'h81, 8'h7E};
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // 1: reset / idle state and STATUS
    repeat (50) @(negedge clk);
    check("idle_tx", {31'b0, uart_tx}, 32'd1);
    check("idle_ack", {31'b0, ack}, 32'd0);
    check("idle_busy", {31'b0, busy}, 32'd0);
    wb_issue(1'b0, 32'h4, 32'h0, 4'hF, 1'b1, 1'b0, 32'h0000_0002);
    wb_idle();
    wait_idle(100);

    // 2: single byte 0x41, busy spans the 40-clk frame plus the sampling clock
    exp_q.push_back(8'h41);
    wb_issue(1'b1, 32'h0, 32'h0000_0041, 4'h1, 1'b1, 1'b0, 32'h0);
    wb_idle();
    busy_cnt = 0;
    while (busy && busy_cnt < 200) begin
      busy_cnt++;
      @(negedge clk);
    end
    check("frame_busy_clks", busy_cnt, 41);
    wait_idle(100);
    check("t2_bytes_left", exp_q.size(), 0);

    // 3: six back-to-back writes into a 4-deep FIFO, then STATUS while full
    frame_start.delete();
    stall_seen = 0;
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(burst[i]);
      wb_issue(1'b1, 32'h0, {24'h0, burst[i]}, 4'h1, 1'b1, 1'b0, 32'h0);
    end
    wb_issue(1'b0, 32'h4, 32'h0, 4'hF, 1'b1, 1'b0, 32'h0000_0405);
    wb_idle();
    check("t3_stall_clks", stall_seen, 38);
    wait_idle(800);
    check("t3_bytes_left", exp_q.size(), 0);
    check("t3_frames", frame_start.size(), 6);
    for (int i = 1; i < frame_start.size(); i++)
      check("t3_frame_spacing", frame_start[i] - frame_start[i-1], 10 * CLK_DIV + 1);

    // 4: reserved offsets give err, FIFO untouched
    wb_issue(1'b0, 32'h8, 32'h0, 4'hF, 1'b0, 1'b1, 32'h0);
    wb_issue(1'b1, 32'hC, 32'h0000_0055, 4'hF, 1'b0, 1'b1, 32'h0);
    wb_issue(1'b0, 32'h4, 32'h0, 4'hF, 1'b1, 1'b0, 32'h0000_0002);
    wb_idle();
    expect_line_idle("t4", 30);

    // 5: TXDATA write without sel[0], STATUS write ignored
    wb_issue(1'b1, 32'h0, 32'h0000_0033, 4'hE, 1'b1, 1'b0, 32'h0);
    wb_issue(1'b1, 32'h4, 32'h0000_FFFF, 4'hF, 1'b1, 1'b0, 32'h0);
    wb_issue(1'b0, 32'h4, 32'h0, 4'hF, 1'b1, 1'b0, 32'h0000_0002);
    wb_idle();
    expect_line_idle("t5", 50);

    // 6: reset in the middle of the DATA phase
    exp_q.push_back(8'h5A);
    exp_q.push_back(8'hC3);
    wb_issue(1'b1, 32'h0, 32'h0000_005A, 4'h1, 1'b1, 1'b0, 32'h0);
    wb_issue(1'b1, 32'h0, 32'h0000_00C3, 4'h1, 1'b1, 1'b0, 32'h0);
    wb_idle();
    repeat (15) @(negedge clk);
    check("t6_pre_busy", {31'b0, busy}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_tx", {31'b0, uart_tx}, 32'd1);
    check("t6_rst_busy", {31'b0, busy}, 32'd0);
    check("t6_rst_ack", {31'b0, ack}, 32'd0);
    exp_q.delete();
    repeat (8) @(negedge clk);
    rst = 1'b0;
    expect_line_idle("t6", 60);
    wb_issue(1'b0, 32'h4, 32'h0, 4'hF, 1'b1, 1'b0, 32'h0000_0002);
    wb_idle();
    wait_idle(100);

    // final report
    check("end_bytes_left", exp_q.size(), 0);
    check("end_resp_left", resp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
